// File: rtl/mux_pkg.sv
// Shared constants and types for the register-file read-path multiplexers.
package mux_pkg;

    localparam int NUM_LANES = 16;
    localparam int SEL_W     = 4;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux2_1.sv
// WIDTH-wide 2-to-1 multiplexer; the leaf of the 16-to-1 tree and the top stage of a 32-to-1 pair.
module mux2_1 #(
    parameter int WIDTH = 1
) (
    input  logic [1:0][WIDTH-1:0] in,
    input  logic                  sel,
    output logic [WIDTH-1:0]      out
);

    assign out = sel ? in[1] : in[0];

endmodule

// File: rtl/mux16_to_1.sv
// Registered 16-to-1 lane multiplexer built as a 4-level tree of mux2_1.
// Define MUX16_TO_1_ASSERT_EN to compile in simulation-only input/result checks.
module mux16_to_1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic [NUM_LANES*WIDTH-1:0] in,
    input  sel_t                       sel,
    output logic [WIDTH-1:0]           out_comb,
    output logic [WIDTH-1:0]           out
);

    logic [WIDTH-1:0] w_l0 [8];
    logic [WIDTH-1:0] w_l1 [4];
    logic [WIDTH-1:0] w_l2 [2];
    logic [WIDTH-1:0] w_l3;
    logic [WIDTH-1:0] r_out;

    genvar i;

    // Level 0 pairs adjacent lanes; each further level halves the candidates on the next sel bit.
    for (i = 0; i < 8; i++) begin : g_l0
        mux2_1 #(.WIDTH(WIDTH)) u_mux (
            .in  ({in[(2*i+1)*WIDTH +: WIDTH], in[(2*i)*WIDTH +: WIDTH]}),
            .sel (sel[0]),
            .out (w_l0[i])
        );
    end

    for (i = 0; i < 4; i++) begin : g_l1
        mux2_1 #(.WIDTH(WIDTH)) u_mux (
            .in  ({w_l0[2*i+1], w_l0[2*i]}),
            .sel (sel[1]),
            .out (w_l1[i])
        );
    end

    for (i = 0; i < 2; i++) begin : g_l2
        mux2_1 #(.WIDTH(WIDTH)) u_mux (
            .in  ({w_l1[2*i+1], w_l1[2*i]}),
            .sel (sel[2]),
            .out (w_l2[i])
        );
    end

    mux2_1 #(.WIDTH(WIDTH)) u_mux_l3 (
        .in  ({w_l2[1], w_l2[0]}),
        .sel (sel[3]),
        .out (w_l3)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else if (en) begin
            r_out <= w_l3;
        end
    end

    assign out_comb = w_l3;
    assign out      = r_out;

`ifdef MUX16_TO_1_ASSERT_EN
    always @(posedge clk) begin
        if (reset_n && en) begin
            if ($isunknown(sel) || $isunknown(in)) begin
                $error("mux16_to_1: X/Z on sel or in at capture");
            end
            if (out_comb !== in[sel*WIDTH +: WIDTH]) begin
                $error("mux16_to_1: out_comb does not match selected lane");
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_mux16_to_1.sv
// Directed self-checking bench for mux16_to_1: 16-to-1, paired 32-to-1, hold, reset and WIDTH=8.
module tb_mux16_to_1;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic [15:0]  in16;
    logic [3:0]   sel16;
    logic [0:0]   comb16;
    logic [0:0]   out16;

    logic [31:0]  in32;
    logic [4:0]   sel32;
    logic [0:0]   comb_lo;
    logic [0:0]   comb_hi;
    logic [0:0]   reg_lo;
    logic [0:0]   reg_hi;
    logic [0:0]   comb32;

    logic [127:0] in128;
    logic [3:0]   sel8;
    logic [7:0]   comb8;
    logic [7:0]   out8;

    int n_cmp;
    int n_bad;
    logic [31:0] exp_q[$];

    mux16_to_1 #(.WIDTH(1)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .in       (in16),
        .sel      (sel16),
        .out_comb (comb16),
        .out      (out16)
    );

    mux16_to_1 #(.WIDTH(1)) u_lo (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .in       (in32[15:0]),
        .sel      (sel32[3:0]),
        .out_comb (comb_lo),
        .out      (reg_lo)
    );

    mux16_to_1 #(.WIDTH(1)) u_hi (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .in       (in32[31:16]),
        .sel      (sel32[3:0]),
        .out_comb (comb_hi),
        .out      (reg_hi)
    );

    mux2_1 #(.WIDTH(1)) u_top32 (
        .in  ({comb_hi, comb_lo}),
        .sel (sel32[4]),
        .out (comb32)
    );

    mux16_to_1 #(.WIDTH(8)) u_dut8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .in       (in128),
        .sel      (sel8),
        .out_comb (comb8),
        .out      (out8)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive16(input logic [15:0] v_in, input logic [3:0] v_sel, input logic v_en);
        @(negedge clk);
        in16  = v_in;
        sel16 = v_sel;
        en    = v_en;
        #1;
    endtask

    // Checks out_comb now and queues the same value for the registered output after the edge.
    task automatic apply_and_capture(input string tag, input logic [15:0] v_in,
                                     input logic [3:0] v_sel, input logic exp_bit);
        logic [31:0] e;
        drive16(v_in, v_sel, 1'b1);
        check_eq({tag, "_comb"}, {31'd0, comb16}, {31'd0, exp_bit});
        exp_q.push_back({31'd0, exp_bit});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_q_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_reg"}, {31'd0, out16}, e);
        end
    endtask

    task automatic check32(input logic [4:0] v_sel, input logic exp_bit);
        @(negedge clk);
        sel32 = v_sel;
        #1;
        check_eq($sformatf("mux32_sel%0d", v_sel), {31'd0, comb32}, {31'd0, exp_bit});
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        en      = 1'b0;
        in16    = '0;
        sel16   = '0;
        in32    = '0;
        sel32   = '0;
        in128   = '0;
        sel8    = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_out16", {31'd0, out16}, 32'd0);
        check_eq("reset_out8", {24'd0, out8}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Pattern 0x8A6B
        apply_and_capture("p8a6b_s0", 16'h8A6B, 4'd0, 1'b1);
        apply_and_capture("p8a6b_s2", 16'h8A6B, 4'd2, 1'b0);
        apply_and_capture("p8a6b_s11", 16'h8A6B, 4'd11, 1'b1);
        apply_and_capture("p8a6b_s15", 16'h8A6B, 4'd15, 1'b1);

        // One-hot lane 5 sweep
        for (int s = 0; s < 16; s++) begin
            drive16(16'h0020, s[3:0], 1'b1);
            check_eq($sformatf("onehot5_sel%0d", s), {31'd0, comb16}, (s == 5) ? 32'd1 : 32'd0);
        end

        // Paired 32-to-1
        in32 = 32'hAA6B_8A6B;
        check32(5'd31, 1'b1);
        check32(5'd27, 1'b1);
        check32(5'd0, 1'b1);
        check32(5'd2, 1'b0);

        // Hold while disabled
        apply_and_capture("hold_load", 16'hFFFF, 4'd3, 1'b1);
        drive16(16'h0000, 4'd3, 1'b0);
        check_eq("hold_comb", {31'd0, comb16}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("hold_reg", {31'd0, out16}, 32'd1);

        // Asynchronous reset between edges, with a load pending
        drive16(16'hFFFF, 4'd3, 1'b1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_async", {31'd0, out16}, 32'd0);
        check_eq("rst_comb_unaffected", {31'd0, comb16}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("rst_held_low", {31'd0, out16}, 32'd0);
        drive16(16'hFFFF, 4'd3, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rst_release_en0", {31'd0, out16}, 32'd0);
        apply_and_capture("rst_first_load", 16'hFFFF, 4'd3, 1'b1);

        // WIDTH=8 lanes 0x10+k
        for (int k = 0; k < 16; k++) begin
            in128[k*8 +: 8] = 8'h10 + k[7:0];
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            sel8 = k[3:0];
            #1;
            check_eq($sformatf("w8_sel%0d", k), {24'd0, comb8}, 32'h10 + k);
        end
        @(posedge clk);
        #1;
        check_eq("w8_reg", {24'd0, out8}, 32'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
